// File: rtl/scarv_soc_arb_pkg.sv
// Shared types and constants for the SoC memif round-robin arbiter.
//   arb_state_t : arbiter FSM states (IDLE, ADDR, RESP)
//   arb_owner_t : index of the requester currently owning the downstream port
//   memif_req_t : address-phase payload carried from a requester to downstream
package scarv_soc_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned ST_W   = 2;

    localparam logic [ST_W-1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [ST_W-1:0] ST_ADDR_ENC = 2'd1;
    localparam logic [ST_W-1:0] ST_RESP_ENC = 2'd2;

    typedef enum logic [ST_W-1:0] {
        IDLE = ST_IDLE_ENC,
        ADDR = ST_ADDR_ENC,
        RESP = ST_RESP_ENC
    } arb_state_t;

    typedef logic arb_owner_t;

    typedef struct packed {
        logic              wen;
        logic [STRB_W-1:0] strb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } memif_req_t;

endpackage

// File: rtl/scarv_soc_memif_arb_if.sv
// Memory interface bundle: one address phase (req/gnt + payload) and one
// response (recv/rdata/error).
//   master : issues requests, receives grant and response
//   slave  : accepts requests, returns grant and response
interface scarv_soc_memif_arb_if;
    import scarv_soc_arb_pkg::*;

    logic              req;
    logic              gnt;
    logic              wen;
    logic [STRB_W-1:0] strb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              recv;
    logic [DATA_W-1:0] rdata;
    logic              error;

    modport master (
        output req, wen, strb, addr, wdata,
        input  gnt, recv, rdata, error
    );

    modport slave (
        input  req, wen, strb, addr, wdata,
        output gnt, recv, rdata, error
    );

endinterface

// File: rtl/scarv_soc_arb_rr.sv
// Combinational two-way round-robin picker.
//   req    : request vector, bit N from requester N
//   prio   : requester favoured when both request
//   valid  : at least one request present
//   winner : selected requester (only meaningful when valid)
module scarv_soc_arb_rr
    import scarv_soc_arb_pkg::*;
(
    input  logic [1:0] req,
    input  arb_owner_t prio,
    output logic       valid,
    output arb_owner_t winner
);

    always_comb begin
        valid  = |req;
        // A lone request wins outright; on contention the pointer decides.
        winner = arb_owner_t'(req[1]);
        if (&req) begin
            winner = prio;
        end
    end

endmodule

// File: rtl/scarv_soc_memif_arb.sv
// Two-requester round-robin arbiter for the SoC external memory interface.
// One outstanding transaction at a time; grant and response paths are
// combinational from the downstream port, gated by the registered owner.
//   f_clk     : clock
//   sys_reset : asynchronous active-high reset
//   m0        : requester 0 (core complex), slave side
//   m1        : requester 1 (DMA / debug bridge), slave side
//   s         : downstream memif port, master side
// Build option: define SCARV_SOC_ARB_TIMEOUT_EN to include the response
// watchdog (TIMEOUT_CYCLES cycles in RESP without s.recv forces an error
// response); otherwise RESP waits indefinitely.
module scarv_soc_memif_arb
    import scarv_soc_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TW             = 16
) (
    input  logic                  f_clk,
    input  logic                  sys_reset,
    scarv_soc_memif_arb_if.slave  m0,
    scarv_soc_memif_arb_if.slave  m1,
    scarv_soc_memif_arb_if.master s
);

    arb_state_t state_q;
    arb_owner_t owner_q;
    arb_owner_t prio_q;

    logic       pick_valid;
    arb_owner_t pick_winner;

    logic              in_addr;
    logic              in_resp;
    memif_req_t        m0_pl;
    memif_req_t        m1_pl;
    memif_req_t        own_pl;
    logic              timeout_c;
    logic              resp_fire;
    logic              resp_err;
    logic [DATA_W-1:0] resp_rdata;

    // Arbitration between the two live requests.
    scarv_soc_arb_rr u_rr (
        .req    ({m1.req, m0.req}),
        .prio   (prio_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    assign in_addr = (state_q == ADDR);
    assign in_resp = (state_q == RESP);

    // Downstream request: owner's payload, forced to zero outside ADDR.
    assign m0_pl  = {m0.wen, m0.strb, m0.addr, m0.wdata};
    assign m1_pl  = {m1.wen, m1.strb, m1.addr, m1.wdata};
    assign own_pl = owner_q ? m1_pl : m0_pl;

    assign s.req   = in_addr;
    assign s.wen   = in_addr & own_pl.wen;
    assign s.strb  = in_addr ? own_pl.strb  : '0;
    assign s.addr  = in_addr ? own_pl.addr  : '0;
    assign s.wdata = in_addr ? own_pl.wdata : '0;

    // Grant is steered to the owner only.
    assign m0.gnt = in_addr & ~owner_q & s.gnt;
    assign m1.gnt = in_addr &  owner_q & s.gnt;

`ifdef SCARV_SOC_ARB_TIMEOUT_EN
    logic [TW-1:0] wdog_q;

    // A real response on the timeout cycle takes precedence.
    assign timeout_c = in_resp & ~s.recv & (wdog_q == TW'(TIMEOUT_CYCLES));

    // Counts cycles spent in RESP; cleared on the ADDR->RESP transition.
    always_ff @(posedge f_clk or posedge sys_reset) begin
        if (sys_reset) begin
            wdog_q <= '0;
        end else if (in_addr && s.gnt) begin
            wdog_q <= '0;
        end else if (in_resp && !s.recv) begin
            wdog_q <= wdog_q + TW'(1);
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    // Response: downstream values, or a zero-data error on watchdog expiry.
    assign resp_fire  = in_resp & (s.recv | timeout_c);
    assign resp_err   = s.recv ? s.error : 1'b1;
    assign resp_rdata = s.recv ? s.rdata : '0;

    assign m0.recv  = resp_fire & ~owner_q;
    assign m1.recv  = resp_fire &  owner_q;
    assign m0.error = m0.recv & resp_err;
    assign m1.error = m1.recv & resp_err;
    assign m0.rdata = m0.recv ? resp_rdata : '0;
    assign m1.rdata = m1.recv ? resp_rdata : '0;

    // Arbiter FSM with owner and round-robin pointer.
    always_ff @(posedge f_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        owner_q <= pick_winner;
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    if (s.gnt) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    // Hand priority to the other requester so a waiting one is served next.
                    if (resp_fire) begin
                        prio_q  <= ~owner_q;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
